// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - RV32I load/store unit constants, FSM states and access legality check
package lsu_pkg;

    // RV32I funct3 width codes
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        CAP,
        WR,
        RESP
    } lsu_state_t;

    // Unsupported width codes fault exactly like misaligned accesses;
    // stores only have the signed codes B/H/W.
    function automatic logic is_fault(input logic store, input logic [2:0] funct3,
                                      input logic [1:0] addr_lo);
        logic f;
        f = 1'b1;
        case (funct3)
            F3_B:    f = 1'b0;
            F3_H:    f = addr_lo[0];
            F3_W:    f = (addr_lo != 2'b00);
            F3_BU:   f = store;
            F3_HU:   f = store | addr_lo[0];
            default: f = 1'b1;
        endcase
        return f;
    endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - load lane extraction/extension and sub-word store merge
//   funct3      : access width code
//   addr_lo     : byte offset within the word
//   mem_word    : word read from memory
//   store_data  : LSB-aligned store data
//   load_data   : extended load result
//   merged_word : mem_word with the addressed lane replaced (or store_data for SW)
module lsu_align
    import lsu_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] mem_word,
    input  logic [31:0] store_data,
    output logic [31:0] load_data,
    output logic [31:0] merged_word
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = mem_word[7:0];
        case (addr_lo)
            2'd0:    byte_sel = mem_word[7:0];
            2'd1:    byte_sel = mem_word[15:8];
            2'd2:    byte_sel = mem_word[23:16];
            default: byte_sel = mem_word[31:24];
        endcase
        half_sel = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
    end

    always_comb begin
        load_data = mem_word;
        case (funct3)
            F3_B:    load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_H:    load_data = {{16{half_sel[15]}}, half_sel};
            F3_BU:   load_data = {24'h0, byte_sel};
            F3_HU:   load_data = {16'h0, half_sel};
            default: load_data = mem_word;
        endcase
    end

    always_comb begin
        merged_word = mem_word;
        case (funct3)
            F3_B: begin
                case (addr_lo)
                    2'd0:    merged_word[7:0]   = store_data[7:0];
                    2'd1:    merged_word[15:8]  = store_data[7:0];
                    2'd2:    merged_word[23:16] = store_data[7:0];
                    default: merged_word[31:24] = store_data[7:0];
                endcase
            end
            F3_H: begin
                if (addr_lo[1]) merged_word[31:16] = store_data[15:0];
                else            merged_word[15:0]  = store_data[15:0];
            end
            F3_W:    merged_word = store_data;
            default: merged_word = mem_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit bridging core requests to a word-wide data memory
//   clk, rst                     : clock, synchronous active-low reset
//   req_*                        : core access request (valid/ready handshake)
//   resp_*                       : completion with load data or alignment fault
//   mem_read/write/addr/wdata    : word access to data memory, one-cycle read latency
//   mem_funct3                   : fixed word width code
//   mem_rdata                    : memory read data
module load_store_unit
    import lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_store,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_funct3,
    input  logic [31:0] mem_rdata
);

    lsu_state_t  state, state_nx;
    logic        store_q;
    logic [2:0]  funct3_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] word_q;
    logic [31:0] rdata_q;
    logic        mis_q;
    logic        fault_in;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    assign fault_in = is_fault(req_store, req_funct3, req_addr[1:0]);

    lsu_align u_align (
        .funct3      (funct3_q),
        .addr_lo     (addr_q[1:0]),
        .mem_word    (mem_rdata),
        .store_data  (wdata_q),
        .load_data   (load_data),
        .merged_word (merged_word)
    );

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (fault_in)                              state_nx = RESP;
                    else if (req_store && req_funct3 == F3_W)  state_nx = WR;
                    else                                       state_nx = RD;
                end
            end
            RD:      state_nx = CAP;
            CAP:     state_nx = store_q ? WR : RESP;
            WR:      state_nx = RESP;
            RESP:    if (resp_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            store_q  <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= 32'h0;
            wdata_q  <= 32'h0;
            word_q   <= 32'h0;
            rdata_q  <= 32'h0;
            mis_q    <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == IDLE && req_valid) begin
                store_q  <= req_store;
                funct3_q <= req_funct3;
                addr_q   <= req_addr;
                wdata_q  <= req_wdata;
                // SW goes straight to WR, so its write word is the request data.
                word_q   <= req_wdata;
                rdata_q  <= 32'h0;
                mis_q    <= fault_in;
            end
            if (state == CAP) begin
                if (store_q) word_q  <= merged_word;
                else         rdata_q <= load_data;
            end
        end
    end

    assign req_ready       = (state == IDLE);
    assign resp_valid      = (state == RESP);
    assign resp_rdata      = rdata_q;
    assign resp_misaligned = mis_q;
    // Gated with reset so an access interrupted by reset never reaches memory
    // on the edge where the reset is taken.
    assign mem_read        = (state == RD) && rst;
    assign mem_write       = (state == WR) && rst;
    assign mem_addr        = {addr_q[31:2], 2'b00};
    assign mem_wdata       = word_q;
    assign mem_funct3      = F3_W;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - self-checking bench for load_store_unit
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rdata = 32'h0;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk             (clk),
        .rst             (rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_store       (req_store),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_rdata      (resp_rdata),
        .resp_misaligned (resp_misaligned),
        .mem_read        (mem_read),
        .mem_write       (mem_write),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_funct3      (mem_funct3),
        .mem_rdata       (mem_rdata)
    );

    // Data memory model: synchronous write, registered one-cycle read.
    logic [31:0] mem [0:15];
    logic        loaded = 1'b0;
    always @(posedge clk) begin
        if (!loaded) begin
            for (int i = 0; i < 16; i++) mem[i] <= 32'h0;
            mem[0] <= 32'h8765F0A1;
            loaded <= 1'b1;
        end else begin
            if (mem_write) mem[mem_addr[5:2]] <= mem_wdata;
            if (mem_read)  mem_rdata <= mem[mem_addr[5:2]];
        end
    end

    int checks = 0;
    int errors = 0;
    int both_hi = 0;

    always @(negedge clk) if (mem_read && mem_write) both_hi++;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_mis;
        int          exp_lat;
        int          exp_rd;
        int          exp_wr;
        logic [31:0] exp_wdata;
    } vec_t;

    typedef struct {
        logic [31:0] rdata;
        logic        mis;
    } resp_t;

    vec_t  vecs[$];
    resp_t sb[$];

    function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] w, input logic [31:0] er, input logic em,
                                input int lat, input int rd, input int wr, input logic [31:0] ew);
        vec_t v;
        v.st = st; v.f3 = f3; v.addr = a; v.wdata = w; v.exp_rdata = er; v.exp_mis = em;
        v.exp_lat = lat; v.exp_rd = rd; v.exp_wr = wr; v.exp_wdata = ew;
        return v;
    endfunction

    task automatic drive_req(input logic st, input logic [2:0] f3, input logic [31:0] a,
                             input logic [31:0] w);
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = w;
    endtask

    task automatic run_vec(input vec_t v);
        int          lat, nrd, nwr;
        logic [31:0] wd;
        bit          seen;
        resp_t       e;
        @(negedge clk);
        check32("req_ready_idle", {31'b0, req_ready}, 32'd1);
        drive_req(v.st, v.f3, v.addr, v.wdata);
        sb.push_back('{rdata: v.exp_rdata, mis: v.exp_mis});
        @(posedge clk);
        #1 req_valid = 1'b0;
        lat = 0; nrd = 0; nwr = 0; wd = 32'h0; seen = 1'b0;
        while (!seen && lat < 20) begin
            @(negedge clk);
            lat++;
            if (mem_read) begin
                nrd++;
                check32("rd_addr", mem_addr, {v.addr[31:2], 2'b00});
            end
            if (mem_write) begin
                nwr++;
                wd = mem_wdata;
                check32("wr_addr", mem_addr, {v.addr[31:2], 2'b00});
            end
            if (resp_valid) seen = 1'b1;
        end
        if (!seen) begin
            checks++; errors++;
            $display("FAIL resp_timeout: got no resp_valid expected one within 20 cycles");
        end else begin
            e = sb.pop_front();
            check32("resp_rdata", resp_rdata, e.rdata);
            check32("resp_misaligned", {31'b0, resp_misaligned}, {31'b0, e.mis});
            check32("latency", 32'(lat), 32'(v.exp_lat));
            check32("mem_read_pulses", 32'(nrd), 32'(v.exp_rd));
            check32("mem_write_pulses", 32'(nwr), 32'(v.exp_wr));
            if (v.exp_wr != 0) check32("mem_wdata", wd, v.exp_wdata);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        resp_t       e;
        logic [31:0] held;
        int          n;
        bit          found;

        vecs.push_back(mk(0, 3'b000, 32'd1, 32'h0,        32'hFFFFFFF0, 0, 3, 1, 0, 32'h0));
        vecs.push_back(mk(0, 3'b101, 32'd2, 32'h0,        32'h00008765, 0, 3, 1, 0, 32'h0));
        vecs.push_back(mk(0, 3'b001, 32'd0, 32'h0,        32'hFFFFF0A1, 0, 3, 1, 0, 32'h0));
        vecs.push_back(mk(0, 3'b010, 32'd0, 32'h0,        32'h8765F0A1, 0, 3, 1, 0, 32'h0));
        vecs.push_back(mk(0, 3'b100, 32'd0, 32'h0,        32'h000000A1, 0, 3, 1, 0, 32'h0));
        vecs.push_back(mk(0, 3'b000, 32'd3, 32'h0,        32'hFFFFFF87, 0, 3, 1, 0, 32'h0));
        vecs.push_back(mk(0, 3'b001, 32'd2, 32'h0,        32'hFFFF8765, 0, 3, 1, 0, 32'h0));
        vecs.push_back(mk(0, 3'b100, 32'd2, 32'h0,        32'h00000065, 0, 3, 1, 0, 32'h0));
        vecs.push_back(mk(1, 3'b000, 32'd3, 32'h000000EE, 32'h0,        0, 4, 1, 1, 32'hEE65F0A1));
        vecs.push_back(mk(0, 3'b010, 32'd0, 32'h0,        32'hEE65F0A1, 0, 3, 1, 0, 32'h0));
        vecs.push_back(mk(0, 3'b010, 32'd2, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1, 3'b001, 32'd1, 32'h00001234, 32'h0,        1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 3'b011, 32'd0, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 3'b110, 32'd0, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1, 3'b100, 32'd0, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(0, 3'b101, 32'd1, 32'h0,        32'h0,        1, 1, 0, 0, 32'h0));
        vecs.push_back(mk(1, 3'b010, 32'd4, 32'h12345678, 32'h0,        0, 2, 0, 1, 32'h12345678));
        vecs.push_back(mk(0, 3'b010, 32'd4, 32'h0,        32'h12345678, 0, 3, 1, 0, 32'h0));
        vecs.push_back(mk(1, 3'b001, 32'd6, 32'h0000BEEF, 32'h0,        0, 4, 1, 1, 32'hBEEF5678));
        vecs.push_back(mk(0, 3'b101, 32'd6, 32'h0,        32'h0000BEEF, 0, 3, 1, 0, 32'h0));
        vecs.push_back(mk(0, 3'b001, 32'd6, 32'h0,        32'hFFFFBEEF, 0, 3, 1, 0, 32'h0));
        vecs.push_back(mk(1, 3'b000, 32'd5, 32'h123456AB, 32'h0,        0, 4, 1, 1, 32'hBEEFAB78));
        vecs.push_back(mk(0, 3'b010, 32'd4, 32'h0,        32'hBEEFAB78, 0, 3, 1, 0, 32'h0));

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check32("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        check32("rst_resp_rdata", resp_rdata, 32'h0);
        check32("rst_resp_mis", {31'b0, resp_misaligned}, 32'd0);
        check32("rst_mem_read", {31'b0, mem_read}, 32'd0);
        check32("rst_mem_write", {31'b0, mem_write}, 32'd0);
        check32("rst_req_ready", {31'b0, req_ready}, 32'd1);
        check32("mem_funct3", {29'b0, mem_funct3}, 32'd2);
        rst = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Response back-pressure: held response stays stable, no new acceptance.
        @(negedge clk);
        resp_ready = 1'b0;
        drive_req(1'b0, 3'b000, 32'd1, 32'h0);
        sb.push_back('{rdata: 32'hFFFFFFF0, mis: 1'b0});
        @(posedge clk);
        #1 drive_req(1'b0, 3'b010, 32'd4, 32'h0);
        n = 0; found = 1'b0;
        while (!found && n < 10) begin
            @(negedge clk);
            n++;
            if (resp_valid) found = 1'b1;
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL stall_timeout: got no resp_valid expected one within 10 cycles");
        end else begin
            e = sb.pop_front();
            held = resp_rdata;
            check32("stall_rdata", held, e.rdata);
            for (int k = 0; k < 5; k++) begin
                if (k > 0) @(negedge clk);
                check32("stall_resp_valid", {31'b0, resp_valid}, 32'd1);
                check32("stall_rdata_hold", resp_rdata, e.rdata);
                check32("stall_req_ready", {31'b0, req_ready}, 32'd0);
            end
            resp_ready = 1'b1;
            @(negedge clk);
            check32("post_resp_idle", {31'b0, req_ready}, 32'd1);
            check32("post_resp_no_read", {31'b0, mem_read}, 32'd0);
            req_valid = 1'b0;
        end
        req_valid = 1'b0;

        // Reset during the write phase of an SB aborts the store.
        @(negedge clk);
        drive_req(1'b1, 3'b000, 32'd0, 32'h00000055);
        @(posedge clk);
        #1 req_valid = 1'b0;
        n = 0; found = 1'b0;
        while (!found && n < 10) begin
            @(negedge clk);
            n++;
            if (mem_write) found = 1'b1;
        end
        if (!found) begin
            checks++; errors++;
            $display("FAIL wr_timeout: got no mem_write expected one within 10 cycles");
        end
        rst = 1'b0;
        @(posedge clk);
        #1;
        check32("abort_resp_valid", {31'b0, resp_valid}, 32'd0);
        check32("abort_resp_rdata", resp_rdata, 32'h0);
        check32("abort_resp_mis", {31'b0, resp_misaligned}, 32'd0);
        check32("abort_mem_read", {31'b0, mem_read}, 32'd0);
        check32("abort_mem_write", {31'b0, mem_write}, 32'd0);
        check32("abort_mem_addr", mem_addr, 32'h0);
        check32("abort_mem_wdata", mem_wdata, 32'h0);
        check32("abort_req_ready", {31'b0, req_ready}, 32'd1);
        check32("abort_mem_word", mem[0], 32'hEE65F0A1);
        @(negedge clk);
        rst = 1'b1;
        n = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (mem_write) n++;
        end
        check32("abort_no_late_write", 32'(n), 32'd0);
        check32("abort_mem_word_after", mem[0], 32'hEE65F0A1);
        run_vec(mk(0, 3'b010, 32'd0, 32'h0, 32'hEE65F0A1, 0, 3, 1, 0, 32'h0));

        check32("read_write_exclusive", 32'(both_hi), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL be a parameter-free module with one clock and synchronous, active-low reset.
REQ-002 The ports SHALL be, in order:
  clk  in  1  rising-edge clock
  rst  in  1  synchronous active-low reset
  req_valid  in  1  core presents access
  req_ready  out  1  LSU accepts access
  req_store  in  1  1=store, 0=load
  req_funct3  in  3  RV32I width code (LB/LH/LW/LBU/LHU; SB/SH/SW)
  req_addr  in  32  byte address
  req_wdata  in  32  store data, LSB-aligned
  resp_valid  out  1  result/completion available
  resp_ready  in  1  core consumes response
  resp_rdata  out  32  extended load data (0 for stores)
  resp_misaligned  out  1  access rejected, alignment fault
  mem_read  out  1  to data_memory MemRead
  mem_write  out  1  to data_memory MemWrite
  mem_addr  out  32  word-aligned address (low 2 bits 0)
  mem_wdata  out  32  full word to write
  mem_funct3  out  3  always 3'b010 (word access)
  mem_rdata  in  32  data_memory read_data

Function
REQ-003 The block SHALL use FSM states IDLE, RD, CAP, WR, RESP.
REQ-004 req_ready SHALL be 1 exactly in IDLE; an access is accepted on a clock edge with req_valid&&req_ready, latching store, funct3, addr and wdata.
REQ-005 Misalignment SHALL be halfword with addr[0]=1 or word with addr[1:0]!=0; a misaligned access SHALL go IDLE->RESP with resp_misaligned=1 and no mem_read/mem_write pulse.
REQ-006 An aligned load or a byte/halfword store SHALL go IDLE->RD->CAP; an aligned word store SHALL go IDLE->WR.
REQ-007 In RD, mem_read SHALL be 1 for exactly one cycle with mem_addr={addr[31:2],2'b00}; mem_rdata SHALL be sampled at the end of CAP (one-cycle memory read latency).
REQ-008 From CAP, a load SHALL go to RESP; a sub-word store SHALL go to WR.
REQ-009 In WR, mem_write SHALL be 1 for exactly one cycle. For SW, mem_wdata=req_wdata. For SB/SH, mem_wdata SHALL be the captured word with only the addressed byte lane (addr[1:0]) or halfword lane (addr[1]) replaced by req_wdata[7:0]/[15:0]. WR SHALL go to RESP.
REQ-010 Load extraction SHALL select the byte lane addr[1:0] or halfword lane addr[1]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass through.
REQ-011 In RESP, resp_valid SHALL be 1 and resp_rdata/resp_misaligned held stable until resp_ready=1, then the FSM returns to IDLE; it SHALL NOT accept a new request in the same cycle.
REQ-012 An unsupported funct3 (011, 110, 111; store codes above 010) SHALL be treated as misaligned (fault, no memory access).
REQ-013 mem_read and mem_write SHALL never be 1 in the same cycle; both SHALL be 0 outside RD/WR.
REQ-014 Minimum latencies from acceptance edge to first resp_valid cycle: load 3 cycles, SW 2, SB/SH 4, fault 1.

Reset
REQ-015 While rst=0 at a clock edge: state=IDLE, resp_valid=0, resp_rdata=0, resp_misaligned=0, mem_read=0, mem_write=0, all latched request fields cleared.
REQ-016 Reset asserted mid-operation (including in RD or WR) SHALL abort the access; no write SHALL be issued after reset releases.

Structure
REQ-017 Package lsu_pkg SHALL hold the funct3 width constants and the FSM state enumeration.
REQ-018 Lane extraction/extension and store merge SHALL be one combinational sub-module lsu_align; the FSM and registers stay in load_store_unit.

Verification
REQ-019 Memory word 0x0 = 0x8765F0A1; LB addr 1 -> resp_rdata=0xFFFFFFF0 on 3rd cycle after acceptance, one mem_read pulse, mem_addr=0.
REQ-020 Same word; LHU addr 2 -> 0x00008765; LH addr 0 -> 0xFFFFF0A1; LW addr 0 -> 0x8765F0A1.
REQ-021 SB addr 3 wdata 0x000000EE -> RD then WR with mem_wdata=0xEE65F0A1; a following LW addr 0 returns 0xEE65F0A1.
REQ-022 LW addr 2 and SH addr 1 -> resp_misaligned=1 one cycle after acceptance, zero mem_read/mem_write pulses.
REQ-023 resp_ready held 0 for 5 cycles -> resp_valid and resp_rdata stable, req_ready=0 throughout.
REQ-024 rst=0 during WR of an SB -> all outputs at reset values next edge, memory word unchanged.
